// File: rtl/mod4_pkg.sv
// Shared types and constants for the mod-4 check scheduler and its engine.
package mod4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

endpackage

// File: rtl/mod4_engine.sv
// Bit-serial mod-4 checker: 2-state Mealy machine, registered state, combinational output.
module mod4_engine
  import mod4_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic in_1,
  input  logic in_2,
  output logic out
);

  logic st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= P0;
    end else if (clr) begin
      st <= P0;
    end else if (en) begin
      st <= in_1 ^ in_2;
    end
  end

  assign out = ((st == P0) & ~in_1 & ~in_2) | ((st == P1) & in_1 & in_2);

endmodule

// File: rtl/mod4_check_sched.sv
// Round-robin scheduler sharing one bit-serial mod-4 engine between NREQ requesters.
//
// state | meaning
// IDLE  | offering a one-hot grant to the next valid requester from rr_ptr
// SHIFT | feeding captured operands LSB-first into the engine, W cycles
// DONE  | holding the tagged result until res_ready
module mod4_check_sched
  import mod4_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ),
  parameter int HW   = $clog2(W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic              res_flag,
  output logic [HW-1:0]     res_hits,
  output logic              busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            accept;
  logic            eng_out;
  logic [IDW-1:0]  next_ptr;

  // First valid requester at or after ptr, wrapping around.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  ptr);
    logic [NREQ-1:0] g;
    logic            found;
    logic [IDW-1:0]  idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && v[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    grant    = rr_pick(req_valid, rr_ptr);
    grant_id = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id = IDW'(i);
        sel_a    = req_a[i*W +: W];
        sel_b    = req_b[i*W +: W];
      end
    end
  end

  // Gated by rst so no grant is offered while the block is held in reset.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign next_ptr  = (res_id == IDW'(NREQ - 1)) ? '0 : res_id + 1'b1;

  mod4_engine u_engine (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state == SHIFT),
    .in_1 (a_sh[0]),
    .in_2 (b_sh[0]),
    .out  (eng_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      cnt      <= '0;
      res_id   <= '0;
      res_flag <= 1'b0;
      res_hits <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh     <= sel_a;
            b_sh     <= sel_b;
            res_id   <= grant_id;
            cnt      <= CW'(W - 1);
            res_hits <= '0;
            res_flag <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          res_hits <= res_hits + HW'(eng_out);
          // cnt counts down the remaining bits; zero marks the MSB cycle.
          if (cnt == '0) begin
            res_flag <= eng_out;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod4_check_sched.sv
// Directed, table-driven bench for mod4_check_sched (NREQ=4, W=8).
module tb_mod4_check_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int HW   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [IDW-1:0]    res_id;
  logic              res_flag;
  logic [HW-1:0]     res_hits;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  mod4_check_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_flag  (res_flag),
    .res_hits  (res_hits),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       flag;
    logic [3:0] hits;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_job(input vec_t v);
    int  lat;
    bit  got;
    req_a[v.id*W +: W] = v.a;
    req_b[v.id*W +: W] = v.b;
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req_ready[v.id]) got = 1;
    end
    chk("grant_seen", 64'(got), 64'd1);
    if (!got) begin
      req_valid = '0;
      return;
    end
    chk("grant_onehot", 64'(req_ready), 64'(4'b1 << v.id));
    @(posedge clk);
    #1;
    req_valid = '0;
    req_a[v.id*W +: W] = ~v.a;
    req_b[v.id*W +: W] = ~v.b;
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (res_valid) got = 1;
    end
    chk("res_latency", 64'(lat), 64'd9);
    chk("res_id", 64'(res_id), 64'(v.id));
    chk("res_flag", 64'(res_flag), 64'(v.flag));
    chk("res_hits", 64'(res_hits), 64'(v.hits));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_id[8];
    int acc_cyc[8];
    int n_acc;
    int lat;
    bit got;
    logic [NREQ-1:0] rr;

    vecs[0] = '{0, 8'h00, 8'h00, 1'b1, 4'd8};
    vecs[1] = '{1, 8'hFF, 8'hFF, 1'b0, 4'd0};
    vecs[2] = '{2, 8'h01, 8'h01, 1'b1, 4'd7};
    vecs[3] = '{3, 8'h03, 8'h01, 1'b1, 4'd5};
    vecs[4] = '{0, 8'hFF, 8'h00, 1'b0, 4'd0};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("reset_outputs", 64'({req_ready, res_valid, res_id, res_flag, res_hits, busy}), 64'd0);

    foreach (vecs[k]) do_job(vecs[k]);

    // All requesters valid: round-robin order and spacing
    req_a = '0;
    req_b = '0;
    req_valid = '1;
    do_reset();
    n_acc = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      rr = req_ready;
      chk("ready_onehot_or_zero", 64'((rr & (rr - 1'b1)) == '0), 64'd1);
      if ((req_valid & req_ready) != '0 && n_acc < 8) begin
        acc_cyc[n_acc] = c;
        acc_id[n_acc] = 0;
        for (int j = 0; j < NREQ; j++) if (rr[j]) acc_id[n_acc] = j;
        n_acc++;
      end
    end
    chk("rr_accept_count", 64'(n_acc >= 5), 64'd1);
    if (n_acc >= 5) begin
      for (int j = 0; j < 5; j++) chk("rr_order", 64'(acc_id[j]), 64'(j % NREQ));
      for (int j = 1; j < 5; j++) chk("rr_spacing", 64'(acc_cyc[j] - acc_cyc[j-1]), 64'd10);
    end

    // Result back-pressure
    req_valid = '1;
    res_ready = 1'b0;
    do_reset();
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1;
    end
    chk("hold_result_seen", 64'(got), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_no_grant", 64'(req_ready), 64'd0);
      chk("hold_result", 64'({res_valid, res_id, res_flag, res_hits}), 64'(8'b1_00_1_1000));
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1;
    end
    chk("hold_next_grant", 64'(req_ready), 64'(4'b0010));

    // Reset in the middle of a job
    req_valid = '0;
    do_reset();
    req_valid = 4'b0011;
    @(negedge clk);
    chk("mid_first_grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_outputs", 64'({req_ready, res_valid, res_id, res_flag, res_hits, busy}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_regrant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (res_valid) got = 1;
    end
    chk("mid_latency", 64'(lat), 64'd9);
    chk("mid_result", 64'({res_id, res_flag, res_hits}), 64'(7'b00_1_1000));
    @(posedge clk);
    @(negedge clk);
    chk("mid_back_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
